// File: rtl/debounce_sync.sv
// Synchronizer plus consecutive-sample debouncer with registered rise/fall pulses.
// Optional glitch counter enabled by defining DB_GLITCH_CNT_EN.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_in,
    input  logic       en,
    output logic       q,
    output logic       qbar,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {StStableLo, StWaitHi, StStableHi, StWaitLo} state_t;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= StStableLo;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // The chain runs regardless of en so s is always fresh.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (en) begin
            case (state_q)
                StStableLo: begin
                    if (s) begin
                        if (DB_CYCLES == 1) begin
                            state_d = StStableHi;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = StWaitHi;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                StWaitHi: begin
                    if (!s) begin
                        state_d = StStableLo;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StStableHi;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStableHi: begin
                    if (!s) begin
                        if (DB_CYCLES == 1) begin
                            state_d = StStableLo;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = StWaitLo;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                StWaitLo: begin
                    if (s) begin
                        state_d = StStableHi;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StStableLo;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign q    = (state_q == StStableHi) || (state_q == StWaitLo);
    assign qbar = ~q;
    assign busy = (state_q == StWaitHi) || (state_q == StWaitLo);
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef DB_GLITCH_CNT_EN
    logic       glitch;
    logic [7:0] glitch_q;

    // A candidate abandoned before qualifying counts as one glitch.
    assign glitch = en && (((state_q == StWaitHi) && !s) || ((state_q == StWaitLo) && s));

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= 8'd0;
        end else if (glitch && (glitch_q != 8'hff)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default instance and a SYNC_STAGES=3/DB_CYCLES=1 instance,
// checked cycle by cycle against a run-length model through a scoreboard queue.
module tb_debounce_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_in = 1'b0;
    logic       en = 1'b1;
    logic       q_a, qbar_a, rise_a, fall_a, busy_a;
    logic       q_b, qbar_b, rise_b, fall_b, busy_b;
    logic [7:0] gc_a, gc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_sync #(.SYNC_STAGES(2), .DB_CYCLES(4), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .d_in(d_in), .en(en), .q(q_a), .qbar(qbar_a),
        .rise(rise_a), .fall(fall_a), .busy(busy_a), .glitch_cnt(gc_a)
    );

    debounce_sync #(.SYNC_STAGES(3), .DB_CYCLES(1), .CNT_W(1)) dut_b (
        .clk(clk), .rst(rst), .d_in(d_in), .en(en), .q(q_b), .qbar(qbar_b),
        .rise(rise_b), .fall(fall_b), .busy(busy_b), .glitch_cnt(gc_b)
    );

    // Model: level plus length of the current run of enabled samples that disagree with it.
    typedef struct {
        logic [7:0] sync;
        logic       q;
        int         run;
        int         gl;
        logic       rise;
        logic       fall;
    } mdl_t;

    typedef struct packed {
        logic       q;
        logic       qbar;
        logic       rise;
        logic       fall;
        logic       busy;
        logic [7:0] gc;
    } exp_t;

    mdl_t m_a, m_b;
    exp_t exp_a[$];
    exp_t exp_b[$];
    int   rise_n_a, fall_n_a, rise_n_b, fall_n_b, busy_n_a;

    function automatic mdl_t mstep(mdl_t m, int ns, int db, logic r, logic d, logic e);
        mdl_t n;
        logic s;
        n = m;
        if (r) begin
            n.sync = 8'd0; n.q = 1'b0; n.run = 0; n.gl = 0; n.rise = 1'b0; n.fall = 1'b0;
            return n;
        end
        s = m.sync[ns-1];
        n.sync = {m.sync[6:0], d};
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (e) begin
            if (s != m.q) begin
                if (m.run + 1 == db) begin
                    n.q = s; n.run = 0; n.rise = s; n.fall = !s;
                end else begin
                    n.run = m.run + 1;
                end
            end else if (m.run > 0) begin
                n.run = 0;
                if (n.gl < 255) n.gl = n.gl + 1;
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(mdl_t m);
        exp_t x;
        x.q = m.q; x.qbar = ~m.q; x.rise = m.rise; x.fall = m.fall; x.busy = (m.run > 0);
`ifdef DB_GLITCH_CNT_EN
        x.gc = 8'(m.gl);
`else
        x.gc = 8'd0;
`endif
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cmp(input string who, input exp_t obs, input exp_t e);
        chk({who, ".q"}, 32'(obs.q), 32'(e.q));
        chk({who, ".qbar"}, 32'(obs.qbar), 32'(e.qbar));
        chk({who, ".rise"}, 32'(obs.rise), 32'(e.rise));
        chk({who, ".fall"}, 32'(obs.fall), 32'(e.fall));
        chk({who, ".busy"}, 32'(obs.busy), 32'(e.busy));
        chk({who, ".glitch_cnt"}, 32'(obs.gc), 32'(e.gc));
    endtask

    task automatic cycle(input logic r, input logic d, input logic e);
        exp_t ea, eb;
        rst = r; d_in = d; en = e;
        @(posedge clk);
        m_a = mstep(m_a, 2, 4, r, d, e);
        m_b = mstep(m_b, 3, 1, r, d, e);
        exp_a.push_back(to_exp(m_a));
        exp_b.push_back(to_exp(m_b));
        #1;
        chk("queue_a", 32'(exp_a.size()), 32'd1);
        chk("queue_b", 32'(exp_b.size()), 32'd1);
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        cmp("a", {q_a, qbar_a, rise_a, fall_a, busy_a, gc_a}, ea);
        cmp("b", {q_b, qbar_b, rise_b, fall_b, busy_b, gc_b}, eb);
        rise_n_a += int'(rise_a); fall_n_a += int'(fall_a);
        rise_n_b += int'(rise_b); fall_n_b += int'(fall_b);
        busy_n_a += int'(busy_a);
    endtask

    task automatic clr_counts();
        rise_n_a = 0; fall_n_a = 0; rise_n_b = 0; fall_n_b = 0; busy_n_a = 0;
    endtask

    initial begin
        int lat_a, lat_b;
        m_a = mstep(m_a, 2, 4, 1'b1, 1'b0, 1'b0);
        m_b = mstep(m_b, 3, 1, 1'b1, 1'b0, 1'b0);
        clr_counts();

        // Reset with d_in high, then release and measure rise latency.
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        clr_counts();
        lat_a = -1; lat_b = -1;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1);
            if (lat_a < 0 && q_a) lat_a = i;
            if (lat_b < 0 && q_b) lat_b = i;
        end
        chk("rise_latency_a", 32'(lat_a), 32'd6);
        chk("rise_latency_b", 32'(lat_b), 32'd4);
        chk("rise_pulses_a", 32'(rise_n_a), 32'd1);
        chk("rise_pulses_b", 32'(rise_n_b), 32'd1);

        // Clean falling edge.
        clr_counts();
        lat_a = -1; lat_b = -1;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            if (lat_a < 0 && !q_a) lat_a = i;
            if (lat_b < 0 && !q_b) lat_b = i;
        end
        chk("fall_latency_a", 32'(lat_a), 32'd6);
        chk("fall_latency_b", 32'(lat_b), 32'd4);
        chk("fall_pulses_a", 32'(fall_n_a), 32'd1);
        chk("rise_during_fall_a", 32'(rise_n_a), 32'd0);

        // Two-cycle glitch: rejected by the default instance.
        clr_counts();
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("glitch_busy_cycles_a", 32'(busy_n_a), 32'd2);
        chk("glitch_rise_a", 32'(rise_n_a), 32'd0);
        chk("glitch_q_a", 32'(q_a), 32'd0);

        // Enable freeze mid-qualification.
        clr_counts();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            chk("freeze_q_a", 32'(q_a), 32'd0);
            chk("freeze_busy_a", 32'(busy_a), 32'd1);
        end
        cycle(1'b0, 1'b1, 1'b1);
        chk("unfreeze_q_a_1", 32'(q_a), 32'd0);
        cycle(1'b0, 1'b1, 1'b1);
        chk("unfreeze_q_a_2", 32'(q_a), 32'd1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1);

        // Reset while the default instance sits in WAIT_HI with cnt=2.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("pre_reset_busy_a", 32'(busy_a), 32'd1);
        cycle(1'b1, 1'b1, 1'b1);
        chk("mid_reset_q_a", 32'(q_a), 32'd0);
        chk("mid_reset_busy_a", 32'(busy_a), 32'd0);
        chk("mid_reset_gc_a", 32'(gc_a), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);

        // Toggle every 2 cycles: the DB_CYCLES=1 instance follows every edge.
        clr_counts();
        for (int t = 0; t < 8; t++) begin
            cycle(1'b0, logic'(t % 2 == 0), 1'b1);
            cycle(1'b0, logic'(t % 2 == 0), 1'b1);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("toggle_rises_b", 32'(rise_n_b), 32'd4);
        chk("toggle_falls_b", 32'(fall_n_b), 32'd4);
        chk("toggle_gc_b", 32'(gc_b), 32'd0);
        chk("toggle_q_a", 32'(rise_n_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
